// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event controller: event type encoding
// and the helper that sizes the button-index field.
package btn_evt_pkg;

  typedef logic [1:0] evt_type_t;

  localparam evt_type_t EVT_PRESS   = 2'd0;
  localparam evt_type_t EVT_RELEASE = 2'd1;
  localparam evt_type_t EVT_LONG    = 2'd2;

  // Width of a button index; a single button still gets a 1-bit field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous show-ahead FIFO. The head is visible while not empty; once
// empty, the output holds the last head shown. A pop frees a slot for a push
// in the same cycle; an empty FIFO never bypasses write data to the output.
module btn_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rd_data = empty ? last_q : mem_q[rd_q];

  // Next-state for storage, pointers, occupancy and the held output value.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = wr_data;
    wr_d   = do_push ? next_ptr(wr_q) : wr_q;
    rd_d   = do_pop ? next_ptr(rd_q) : rd_q;
    cnt_d  = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    last_d = rd_data;
  end

  // State registers, all cleared by reset so the output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/btn_evt_ctrl.sv
// Multi-button event controller: synchronises and debounces N_BTN buttons on
// a shared sample tick, turns level flips and long holds into events, and
// serialises them round-robin into a small FIFO for a valid/ready consumer.
module btn_evt_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int CLKS_PER_SMPL = 16,
  parameter int SMPL_CNT      = 4,
  parameter int LONG_SMPLS    = 64,
  parameter int FIFO_DEPTH    = 4,
  localparam int ID_W         = id_width(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int CNT_W  = (CLKS_PER_SMPL > 1) ? $clog2(CLKS_PER_SMPL) : 1;
  localparam int STAB_W = $clog2(SMPL_CNT);
  localparam int HOLD_W = $clog2(LONG_SMPLS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic             ovf_q, ovf_d;

  logic [N_BTN-1:0] pend_vld;
  logic [1:0]       pend_type [N_BTN];
  logic [N_BTN-1:0] drop_vec;
  logic [N_BTN-1:0] grant;

  logic             found, push, pop;
  logic [ID_W-1:0]  win;
  logic [ID_W+1:0]  fifo_wdata, fifo_rdata;
  logic             fifo_full, fifo_empty;

  assign tick = (cnt_q == CNT_W'(CLKS_PER_SMPL - 1));

  // Shared tick counter, input synchronisers, round-robin pointer and the
  // sticky overflow flag (a new drop wins over a clear in the same cycle).
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    sync1_d = btn;
    sync2_d = sync1_q;
    ovf_d   = ovf_q;
    if (ovf_clr)   ovf_d = 1'b0;
    if (|drop_vec) ovf_d = 1'b1;
  end

  // Registers for the shared control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      rr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rr_q    <= rr_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              lvl_q, lvl_d;
    logic              pend_vld_q, pend_vld_d;
    logic [1:0]        pend_type_q, pend_type_d;
    logic              new_vld, drop;
    logic [1:0]        new_type;

    // Debounce, hold timing and the single-entry pending slot; a flip takes
    // priority over a LONG, so a release on the saturating tick gives no LONG.
    always_comb begin
      stab_d   = stab_q;
      hold_d   = hold_q;
      lvl_d    = lvl_q;
      new_vld  = 1'b0;
      new_type = EVT_PRESS;
      if (tick) begin
        if (sync2_q[i] == lvl_q) begin
          stab_d = '0;
        end else if (stab_q == STAB_W'(SMPL_CNT - 1)) begin
          stab_d   = '0;
          lvl_d    = ~lvl_q;
          new_vld  = 1'b1;
          new_type = lvl_q ? EVT_RELEASE : EVT_PRESS;
          if (!lvl_q) hold_d = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
        if (lvl_q && lvl_d && (hold_q != HOLD_W'(LONG_SMPLS))) begin
          hold_d = hold_q + 1'b1;
          if (hold_d == HOLD_W'(LONG_SMPLS)) begin
            new_vld  = 1'b1;
            new_type = EVT_LONG;
          end
        end
      end
      pend_vld_d  = pend_vld_q;
      pend_type_d = pend_type_q;
      drop        = 1'b0;
      if (grant[i]) pend_vld_d = 1'b0;
      if (new_vld) begin
        if (pend_vld_d) begin
          drop = 1'b1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_type_d = new_type;
        end
      end
    end

    // Per-button registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_q      <= '0;
        hold_q      <= '0;
        lvl_q       <= 1'b0;
        pend_vld_q  <= 1'b0;
        pend_type_q <= EVT_PRESS;
      end else begin
        stab_q      <= stab_d;
        hold_q      <= hold_d;
        lvl_q       <= lvl_d;
        pend_vld_q  <= pend_vld_d;
        pend_type_q <= pend_type_d;
      end
    end

    assign lvl[i]       = lvl_q;
    assign pend_vld[i]  = pend_vld_q;
    assign pend_type[i] = pend_type_q;
    assign drop_vec[i]  = drop;
  end

  // Round-robin pick of the first pending button at or after rr_q; pushes
  // whenever the FIFO has room, counting a slot freed by this cycle's pop.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!found && pend_vld[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    push  = found && (!fifo_full || pop);
    grant = '0;
    if (push) grant[win] = 1'b1;
    rr_d = rr_q;
    if (push) rr_d = (int'(win) == N_BTN - 1) ? '0 : win + 1'b1;
    fifo_wdata = {win, pend_type[win]};
  end

  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign evt_id    = fifo_rdata[ID_W+1:2];
  assign evt_type  = fifo_rdata[1:0];
  assign ovf       = ovf_q;

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W + 2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (fifo_wdata),
    .pop     (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Testbench for btn_evt_ctrl: a vector table for debounce/latency/glitch
// behaviour, then hand-written sequences for long press, round-robin bursts,
// FIFO backpressure with overflow, and reset in mid-stream.
module tb_btn_evt_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;
  logic [3:0] lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  logic [3:0] got [$];

  typedef struct {
    bit         rst;
    logic [3:0] btn;
    int         cycles;
    logic [3:0] exp_lvl;
    logic       exp_valid;
    logic       exp_ovf;
    int         exp_nevt;
    logic [3:0] exp_last;
  } vec_t;

  vec_t vecs [9];
  logic [3:0] exp4 [11];
  logic [3:0] exp5 [5];

  btn_evt_ctrl #(
    .N_BTN         (4),
    .CLKS_PER_SMPL (16),
    .SMPL_CNT      (4),
    .LONG_SMPLS    (8),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .lvl       (lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted event as {id, type}, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) got.push_back({evt_id, evt_type});
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkEvt(input string name, input int idx, input logic [3:0] expected);
    checks++;
    if (idx >= got.size()) begin
      failures++;
      $display("[TB] FAIL %s: event %0d missing (only %0d seen) expected %0h", name, idx, got.size(), expected);
    end else if (got[idx] !== expected) begin
      failures++;
      $display("[TB] FAIL %s: event %0d got %0h expected %0h", name, idx, got[idx], expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic rdy, input int n);
    btn       = b;
    evt_ready = rdy;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc_cnt++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    got.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cyc_cnt = 0;
  endtask

  initial begin
    rst_n     = 1'b1;
    btn       = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    vecs[0] = '{1'b1, 4'b0100, 48, 4'b0000, 1'b0, 1'b0, 0, 4'h0};
    vecs[1] = '{1'b0, 4'b0100, 16, 4'b0100, 1'b0, 1'b0, 0, 4'h0};
    vecs[2] = '{1'b0, 4'b0100,  1, 4'b0100, 1'b1, 1'b0, 0, 4'h0};
    vecs[3] = '{1'b0, 4'b0100,  1, 4'b0100, 1'b0, 1'b0, 1, 4'b1000};
    vecs[4] = '{1'b0, 4'b0100, 94, 4'b0100, 1'b0, 1'b0, 1, 4'b1000};
    vecs[5] = '{1'b1, 4'b0001, 48, 4'b0000, 1'b0, 1'b0, 0, 4'h0};
    vecs[6] = '{1'b0, 4'b0000, 96, 4'b0000, 1'b0, 1'b0, 0, 4'h0};
    vecs[7] = '{1'b0, 4'b0001, 64, 4'b0001, 1'b0, 1'b0, 0, 4'h0};
    vecs[8] = '{1'b0, 4'b0001,  2, 4'b0001, 1'b0, 1'b0, 1, 4'b0000};

    exp4 = '{4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b0101,
             4'b1010, 4'b1110, 4'b0010, 4'b1001, 4'b1101, 4'b0001};
    exp5 = '{4'b0000, 4'b0100, 4'b1000, 4'b1100, 4'b0001};

    // Reset state while reset is held.
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset lvl", 32'(lvl), 0);
    checkOutput("reset evt_valid", 32'(evt_valid), 0);
    checkOutput("reset evt_id", 32'(evt_id), 0);
    checkOutput("reset evt_type", 32'(evt_type), 0);
    checkOutput("reset ovf", 32'(ovf), 0);

    // Table: clean press of btn2 with latency, then a 3-tick glitch on btn0
    // followed by a real 4-tick press.
    for (int r = 0; r < 9; r++) begin
      if (vecs[r].rst) doReset();
      applyStimulus(vecs[r].btn, 1'b1, vecs[r].cycles);
      checkOutput($sformatf("vec%0d lvl", r), 32'(lvl), 32'(vecs[r].exp_lvl));
      checkOutput($sformatf("vec%0d evt_valid", r), 32'(evt_valid), 32'(vecs[r].exp_valid));
      checkOutput($sformatf("vec%0d ovf", r), 32'(ovf), 32'(vecs[r].exp_ovf));
      checkOutput($sformatf("vec%0d nevt", r), got.size(), vecs[r].exp_nevt);
      if (vecs[r].exp_nevt > 0) checkEvt($sformatf("vec%0d last", r), vecs[r].exp_nevt - 1, vecs[r].exp_last);
    end

    // Long press on btn1: PRESS at tick 4, LONG at tick 12, RELEASE at tick 24.
    doReset();
    applyStimulus(4'b0010, 1'b1, 66);
    checkOutput("long nevt@press", got.size(), 1);
    checkEvt("long press", 0, 4'b0100);
    applyStimulus(4'b0010, 1'b1, 112);
    checkOutput("long nevt@tick11", got.size(), 1);
    applyStimulus(4'b0010, 1'b1, 16);
    checkOutput("long nevt@tick12", got.size(), 2);
    checkEvt("long long", 1, 4'b0110);
    applyStimulus(4'b0010, 1'b1, 126);
    applyStimulus(4'b0000, 1'b1, 66);
    checkOutput("long nevt@release", got.size(), 3);
    checkEvt("long release", 2, 4'b0101);
    checkOutput("long lvl@release", 32'(lvl), 0);
    applyStimulus(4'b0000, 1'b1, 160);
    checkOutput("long nevt final", got.size(), 3);

    // Simultaneous burst, single release, then a burst starting from rr=2.
    doReset();
    applyStimulus(4'b1111, 1'b1, 68);
    checkOutput("burst nevt@+4", got.size(), 3);
    applyStimulus(4'b1111, 1'b1, 1);
    checkOutput("burst nevt@+5", got.size(), 4);
    applyStimulus(4'b1111, 1'b1, 11);
    applyStimulus(4'b1101, 1'b1, 66);
    checkOutput("burst nevt@rel1", got.size(), 5);
    applyStimulus(4'b1101, 1'b1, 14);
    applyStimulus(4'b0000, 1'b1, 70);
    checkOutput("burst nevt final", got.size(), 11);
    for (int i = 0; i < 11; i++) checkEvt($sformatf("burst evt%0d", i), i, exp4[i]);

    // Backpressure: FIFO fills, btn0 RELEASE waits, re-press is dropped.
    doReset();
    applyStimulus(4'b0001, 1'b0, 64);
    applyStimulus(4'b1110, 1'b0, 64);
    applyStimulus(4'b1111, 1'b0, 5);
    checkOutput("bp lvl@full", 32'(lvl), 32'(4'b1110));
    checkOutput("bp valid@full", 32'(evt_valid), 1);
    checkOutput("bp head", 32'({evt_id, evt_type}), 0);
    checkOutput("bp ovf@full", 32'(ovf), 0);
    applyStimulus(4'b1111, 1'b0, 61);
    checkOutput("bp lvl@drop", 32'(lvl), 32'(4'b1111));
    checkOutput("bp ovf@drop", 32'(ovf), 1);
    checkOutput("bp nevt@drop", got.size(), 0);
    applyStimulus(4'b1111, 1'b1, 8);
    checkOutput("bp nevt drained", got.size(), 5);
    for (int i = 0; i < 5; i++) checkEvt($sformatf("bp evt%0d", i), i, exp5[i]);
    checkOutput("bp ovf sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    applyStimulus(4'b1111, 1'b1, 1);
    ovf_clr = 1'b0;
    checkOutput("bp ovf cleared", 32'(ovf), 0);

    // Reset mid-stream with three queued events, btn0 held through release.
    doReset();
    applyStimulus(4'b0111, 1'b0, 69);
    checkOutput("mid valid before", 32'(evt_valid), 1);
    checkOutput("mid lvl before", 32'(lvl), 32'(4'b0111));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid valid in reset", 32'(evt_valid), 0);
    checkOutput("mid lvl in reset", 32'(lvl), 0);
    checkOutput("mid ovf in reset", 32'(ovf), 0);
    btn       = 4'b0001;
    evt_ready = 1'b1;
    doReset();
    applyStimulus(4'b0001, 1'b1, 64);
    checkOutput("mid lvl after", 32'(lvl), 32'(4'b0001));
    applyStimulus(4'b0001, 1'b1, 1);
    checkOutput("mid nevt@65", got.size(), 0);
    applyStimulus(4'b0001, 1'b1, 1);
    checkOutput("mid nevt@66", got.size(), 1);
    checkEvt("mid press", 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
